// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator side of a pipelined ALU. Issues tagged requests
// to the ALU and tracks each one through the fixed ALU latency. Results are
// captured into a response FIFO and returned in request order. Credit-based
// admission means a captured result always has a FIFO slot waiting for it.
//
// Handshake semantics (both ports): a transfer happens on the rising clk edge
// where valid and ready are both high. A source holds its payload stable while
// valid is high and ready is low. A sink may change ready at any time.
// Response payload stays stable while rsp_valid is high and rsp_ready is low.
module alu_cmd_issuer #(
  parameter int WIDTH     = 32,
  parameter int OPW       = 4,
  parameter int SHW       = 5,
  parameter int TAGW      = 4,
  parameter int ALU_LAT   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [SHW-1:0]   req_shift,
  input  logic [TAGW-1:0]  req_tag,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [SHW-1:0]   alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             idle
);

  localparam int PIPE = ALU_LAT + 1;
  localparam int PW   = $clog2(RSP_DEPTH);
  localparam int EW   = WIDTH + 2 + TAGW;

  logic            req_fire;
  logic            rsp_fire;
  logic [PIPE-1:0] pipe_v;
  logic [TAGW-1:0] pipe_tag [PIPE];
  logic [OPW-1:0]  pipe_op  [PIPE];
  logic [PW:0]     inflight;
  logic [PW:0]     fifo_count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [EW-1:0]   fifo_mem [RSP_DEPTH];
  logic [EW-1:0]   last_pop;
  logic [EW-1:0]   head_word;
  logic [EW-1:0]   cap_word;
  logic            cap_en;
  logic            cap_err;
  logic            cap_carry;
  logic [OPW-1:0]  last_op;
  logic            credit_ok;

  // Count valid tracking stages; these ops already own a FIFO credit.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE; i++) begin
      inflight = inflight + (PW+1)'(pipe_v[i]);
    end
  end

  // Admission: queued plus in-flight must leave room; a same-cycle pop gives no credit.
  always_comb begin
    credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (PW+2)'(RSP_DEPTH);
    req_ready = rst_n && credit_ok;
    req_fire  = req_valid && req_ready;
  end

  // ALU input registers load on an accepted request and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
    end else if (req_fire) begin
      alu_opcode     <= req_opcode;
      alu_input1     <= req_a;
      alu_input2     <= req_b;
      alu_shiftValue <= req_shift;
    end
  end

  // Tracking pipe: one stage per edge so the last stage lines up with the ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pipe_tag[i] <= '0;
        pipe_op[i]  <= '0;
      end
    end else begin
      pipe_v      <= {pipe_v[PIPE-2:0], req_fire};
      pipe_tag[0] <= req_tag;
      pipe_op[0]  <= req_opcode;
      for (int i = 1; i < PIPE; i++) begin
        pipe_tag[i] <= pipe_tag[i-1];
        pipe_op[i]  <= pipe_op[i-1];
      end
    end
  end

  // Build the capture word: carry only means something for ADD/SUB, errors zero the payload.
  always_comb begin
    last_op   = pipe_op[PIPE-1];
    cap_en    = pipe_v[PIPE-1];
    cap_err   = (last_op == OPW'(7)) || (last_op > OPW'(9));
    cap_carry = !cap_err && alu_carry &&
                ((last_op == OPW'(0)) || (last_op == OPW'(1)));
    cap_word  = {(cap_err ? {WIDTH{1'b0}} : alu_result), cap_carry, cap_err,
                 pipe_tag[PIPE-1]};
  end

  // FIFO storage; contents only matter between write and pop, so no reset.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      fifo_mem[wr_ptr] <= cap_word;
    end
  end

  // FIFO pointers, occupancy and the last-popped word shown while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_pop   <= '0;
    end else begin
      if (cap_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rsp_fire) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= fifo_mem[rd_ptr];
      end
      case ({cap_en, rsp_fire})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // First-word fall-through response view.
  always_comb begin
    rsp_valid  = (fifo_count != '0);
    rsp_fire   = rsp_valid && rsp_ready;
    head_word  = rsp_valid ? fifo_mem[rd_ptr] : last_pop;
    rsp_result = head_word[EW-1 -: WIDTH];
    rsp_carry  = head_word[TAGW+1];
    rsp_err    = head_word[TAGW];
    rsp_tag    = head_word[TAGW-1:0];
    idle       = (inflight == '0) && (fifo_count == '0);
  end

  // A capture into a full FIFO would lose a result; credit admission must prevent it.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(cap_en && !rsp_fire && (fifo_count == (PW+1)'(RSP_DEPTH))));

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a behavioural ALU with two-edge latency sits
// behind the issuer. A response model predicts every handshake, validity
// cycle and payload from the request fields alone.
module tb_alu_cmd_issuer;
  localparam int WIDTH = 32, OPW = 4, SHW = 5, TAGW = 4, ALU_LAT = 2, RSP_DEPTH = 4;
  localparam int EW = WIDTH + 2 + TAGW;

  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready;
  logic [OPW-1:0] req_opcode = '0;
  logic [WIDTH-1:0] req_a = '0, req_b = '0;
  logic [SHW-1:0] req_shift = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic [OPW-1:0] alu_opcode;
  logic [WIDTH-1:0] alu_input1, alu_input2, alu_result;
  logic [SHW-1:0] alu_shiftValue;
  logic alu_carry;
  logic rsp_valid, rsp_ready = 1, rsp_carry, rsp_err, idle;
  logic [WIDTH-1:0] rsp_result;
  logic [TAGW-1:0] rsp_tag;

  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [EW-1:0] exp_q[$];
  int acc_q[$];
  logic [EW-1:0] pop_log[$];
  int pop_cyc[$];
  logic rand_rdy = 0;
  int sz;
  logic exp_v;

  alu_cmd_issuer #(.WIDTH(WIDTH), .OPW(OPW), .SHW(SHW), .TAGW(TAGW),
                   .ALU_LAT(ALU_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .req_tag(req_tag), .alu_opcode(alu_opcode), .alu_input1(alu_input1),
    .alu_input2(alu_input2), .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
    .alu_carry(alu_carry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag), .idle(idle)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in: carry is junk (1) for non-ADD/SUB, unsupported ops give nonzero data
  function automatic logic [WIDTH:0] alu_behav(input logic [OPW-1:0] op,
      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh);
    logic [WIDTH:0] s;
    case (op)
      4'd0: s = {1'b0, a} + {1'b0, b};
      4'd1: s = {(a < b), a - b};
      4'd2: s = {1'b1, a * b};
      4'd3: s = {1'b1, a << sh};
      4'd4: s = {1'b1, ~(a & b)};
      4'd5: s = {1'b1, a | b};
      4'd6: s = {1'b1, ~(a | b)};
      4'd7: s = {1'b1, 31'd0, (a == b)};
      4'd8: s = {1'b1, (a > b) ? a : b};
      4'd9: s = {1'b1, a & b};
      default: s = {1'b1, a ^ b};
    endcase
    return s;
  endfunction

  logic [WIDTH:0] alu_p1 = '0, alu_p2 = '0;
  always @(posedge clk) begin
    alu_p1 <= alu_behav(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    alu_p2 <= alu_p1;
  end
  assign alu_result = alu_p2[WIDTH-1:0];
  assign alu_carry  = alu_p2[WIDTH];

  // expected response word from the request fields
  function automatic logic [EW-1:0] model_word(input logic [OPW-1:0] op,
      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh,
      input logic [TAGW-1:0] tag);
    logic [63:0] w;
    logic [WIDTH-1:0] r;
    logic c, e;
    w = 64'd0; c = 1'b0;
    e = (op == 4'd7) || (op > 4'd9);
    case (op)
      4'd0: begin w = {32'd0, a} + {32'd0, b}; c = w[32]; end
      4'd1: begin w = {32'd0, a} - {32'd0, b}; c = w[63]; end
      4'd2: w = {32'd0, a} * {32'd0, b};
      4'd3: w = {32'd0, a} * (64'd1 << sh);
      4'd4: w = {32'd0, ~(a & b)};
      4'd5: w = {32'd0, a | b};
      4'd6: w = {32'd0, ~(a | b)};
      4'd8: w = ({32'd0, a} > {32'd0, b}) ? {32'd0, a} : {32'd0, b};
      4'd9: w = {32'd0, a & b};
      default: w = 64'd0;
    endcase
    r = w[WIDTH-1:0];
    return {r, c, e, tag};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard / compare process, sampled at the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      sz = exp_q.size();
      check("idle", idle, sz == 0);
      check("req_ready", req_ready, sz < RSP_DEPTH);
      exp_v = 1'b0;
      if (sz > 0) exp_v = (cyc >= acc_q[0] + ALU_LAT + 1);
      check("rsp_valid", rsp_valid, exp_v);
      if (rsp_valid && exp_v) begin
        check("rsp_word", {rsp_result, rsp_carry, rsp_err, rsp_tag}, exp_q[0]);
        if (rsp_ready) begin
          pop_log.push_back({rsp_result, rsp_carry, rsp_err, rsp_tag});
          pop_cyc.push_back(cyc);
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(model_word(req_opcode, req_a, req_b, req_shift, req_tag));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  // random response back-pressure driver
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // driver tasks
  task automatic do_req(input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh, input logic [TAGW-1:0] tag);
    int k;
    req_valid = 1; req_opcode = op; req_a = a; req_b = b; req_shift = sh; req_tag = tag;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin k++; @(negedge clk); end
    check("req_accept", req_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic idle_req();
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!idle && k < 300) begin k++; @(negedge clk); end
    check("wait_idle", idle, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    pop_log.delete();
    pop_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main directed sequence
  initial begin
    int hs, n_acc, k;
    logic hs_now;
    #3;
    check("rst_req_ready", req_ready, 0);
    check("rst_idle", idle, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_word", {rsp_result, rsp_carry, rsp_err, rsp_tag}, 0);
    check("rst_alu", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}, 0);
    #19 rst_n = 1;
    @(posedge clk); #1;

    // ADD with carry-out, latency pin
    clear_log();
    do_req(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 4'd3);
    hs = cyc;
    check("issue_alu_in1", alu_input1, 32'hFFFF_FFFF);
    idle_req();
    wait_idle();
    check("add_count", pop_log.size(), 1);
    check("add_latency", pop_cyc[0] - hs, 3);
    check("add_word", pop_log[0], {32'h0, 1'b1, 1'b0, 4'd3});

    // back-to-back SUB / MUL / SLL
    clear_log();
    do_req(4'd1, 32'd5, 32'd7, 5'd0, 4'd4);
    do_req(4'd2, 32'h0001_0000, 32'h0001_0000, 5'd0, 4'd5);
    do_req(4'd3, 32'd1, 32'd0, 5'd31, 4'd6);
    idle_req();
    wait_idle();
    check("b2b_count", pop_log.size(), 3);
    check("sub_word", pop_log[0], {32'hFFFF_FFFE, 1'b1, 1'b0, 4'd4});
    check("mul_word", pop_log[1], {32'h0000_0000, 1'b0, 1'b0, 4'd5});
    check("sll_word", pop_log[2], {32'h8000_0000, 1'b0, 1'b0, 4'd6});
    check("b2b_gap1", pop_cyc[1] - pop_cyc[0], 1);
    check("b2b_gap2", pop_cyc[2] - pop_cyc[1], 1);

    // credit limit under back-pressure
    clear_log();
    rsp_ready = 0;
    n_acc = 0;
    req_valid = 1; req_opcode = 4'd0; req_a = 32'd0; req_b = 32'd1; req_shift = 5'd0; req_tag = 4'd0;
    repeat (20) begin
      @(negedge clk); hs_now = req_ready;
      @(posedge clk); #1;
      if (hs_now) begin
        n_acc++;
        req_tag = TAGW'(n_acc);
        req_a = WIDTH'(n_acc);
      end
    end
    check("credit_accepts", n_acc, 4);
    check("credit_ready_low", req_ready, 0);
    rsp_ready = 1;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin k++; @(negedge clk); end
    check("tag4_accept", req_ready, 1);
    @(posedge clk); #1;
    do_req(4'd0, 32'd5, 32'd1, 5'd0, 4'd5);
    idle_req();
    wait_idle();
    check("drain_count", pop_log.size(), 6);
    for (int i = 0; i < 6; i++) check("drain_tag", pop_log[i][TAGW-1:0], i);

    // unsupported opcodes then AND
    clear_log();
    do_req(4'd7, 32'd5, 32'd5, 5'd0, 4'd1);
    do_req(4'd12, 32'd3, 32'd9, 5'd0, 4'd2);
    do_req(4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 4'd3);
    idle_req();
    wait_idle();
    check("err_count", pop_log.size(), 3);
    check("seq_word", pop_log[0], {32'h0, 1'b0, 1'b1, 4'd1});
    check("op12_word", pop_log[1], {32'h0, 1'b0, 1'b1, 4'd2});
    check("and_word", pop_log[2], {32'hF000_F000, 1'b0, 1'b0, 4'd3});

    // reset with ops in flight
    clear_log();
    do_req(4'd0, 32'd1, 32'd2, 5'd0, 4'd7);
    do_req(4'd5, 32'd4, 32'd8, 5'd0, 4'd8);
    idle_req();
    @(posedge clk); #1;
    rst_n = 0;
    #2;
    check("midrst_idle", idle, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_alu", {alu_opcode, alu_input1, alu_input2}, 0);
    @(negedge clk); #2;
    rst_n = 1;
    #1;
    check("release_req_ready", req_ready, 1);
    check("release_idle", idle, 1);
    repeat (10) begin
      @(negedge clk); #1;
      check("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    check("no_stale_log", pop_log.size(), 0);

    // random ops with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      do_req(OPW'($urandom_range(0, 9)), $urandom, $urandom,
             SHW'($urandom_range(0, 31)), TAGW'(i));
      if ($urandom_range(0, 4) == 0) begin
        idle_req();
        @(posedge clk); #1;
      end
    end
    idle_req();
    rand_rdy = 0;
    rsp_ready = 1;
    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the pipelined 32-bit ALU interface.
- Accepts tagged operation requests on a valid/ready port and drives the ALU's opcode, operand and shift inputs.
- Tracks every in-flight operation through the ALU's fixed latency, captures result and carry, and returns them in order on a valid/ready response port.
- Credit-based admission guarantees no result is ever dropped under response back-pressure.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 4, opcode width.
- SHW, 5, shift-amount width.
- TAGW, 4, request tag width.
- ALU_LAT, 2, ALU latency: edges from the ALU sampling its inputs to its result being sampleable.
- RSP_DEPTH, 4, response FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when both req_valid and req_ready are high
- req_opcode  in  OPW  ALU opcode (0 ADD, 1 SUB, 2 MUL, 3 SLL, 4 NAND, 5 OR, 6 NOR, 7 SEQ, 8 MAX, 9 AND)
- req_a  in  WIDTH  operand 1
- req_b  in  WIDTH  operand 2
- req_shift  in  SHW  shift amount
- req_tag  in  TAGW  tag echoed on the response
- alu_opcode  out  OPW  to ALU opcode
- alu_input1  out  WIDTH  to ALU input1
- alu_input2  out  WIDTH  to ALU input2
- alu_shiftValue  out  SHW  to ALU shiftValue
- alu_result  in  WIDTH  from ALU result
- alu_carry  in  1  from ALU carryFlag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high
- rsp_result  out  WIDTH  operation result
- rsp_carry  out  1  carry/borrow (ADD/SUB only)
- rsp_err  out  1  unsupported opcode
- rsp_tag  out  TAGW  echoed tag
- idle  out  1  no op in flight and response FIFO empty

Behaviour:
- Reset (rst_n low, asynchronous):
  - All alu_* outputs 0.
  - In-flight pipe cleared, FIFO pointers and count 0.
  - rsp_valid 0; rsp_result, rsp_carry, rsp_err, rsp_tag 0.
  - req_ready 0 while rst_n is low; idle 1.
- Reset mid-operation: all in-flight ops and queued responses are discarded; no stale response appears after release.
- ALU reset is driven separately at top level and is outside this block.
- Issue:
  - On handshake at edge N, the alu_* registers load the req_* fields at edge N.
  - The ALU samples them at N+1. alu_result/alu_carry are sampled at edge N+1+ALU_LAT (N+3 at default).
  - alu_* registers hold their last value when no handshake occurs.
- Tracking pipe: ALU_LAT+1 stages of {valid, tag, opcode}, shifting every cycle. The stage-0 valid bit is set on handshake.
- Capture: when the last stage is valid, write {alu_result, carry_m, err, tag} into the response FIFO at that edge.
  - carry_m = alu_carry if opcode is 0 or 1, else 0.
  - err = 1 if opcode is 7 or > 9; for err, the stored result is forced to 0 and carry to 0.
- Request-to-response latency: rsp_valid rises after edge N+ALU_LAT+1 if the FIFO was empty. Zero-bubble back-to-back issue gives one response per cycle.
- Credit rule: req_ready = rst_n && (fifo_count + inflight_count < RSP_DEPTH).
  - inflight_count is the number of valid pipe stages.
  - A same-cycle FIFO pop does not add credit that cycle (conservative).
  - The FIFO therefore never overflows; an overflow-write assertion is required.
- Response FIFO:
  - First-word fall-through; rsp_* show the head entry.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous capture and pop: count unchanged, both pointers advance. Pointers wrap modulo RSP_DEPTH.
  - Empty: rsp_valid 0, rsp_* hold the last popped values.
  - rsp_* are stable while rsp_valid && !rsp_ready.
- Ordering: responses are returned strictly in request order.
- idle = (inflight_count == 0) && (fifo_count == 0).

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001, tag=3, handshake at edge N -> rsp_valid after N+3; result 0x00000000, carry 1, err 0, tag 3.
- SUB 5-7 then MUL 0x10000*0x10000 then SLL 1<<31 back-to-back, rsp_ready=1 -> three consecutive rsp_valid cycles:
  - 0xFFFFFFFE carry 1;
  - 0x00000000 carry 0;
  - 0x80000000 carry 0.
- rsp_ready=0, req_valid held high with 6 distinct tags -> exactly 4 accepted, req_ready low from then on. Raising rsp_ready drains tags 0..3 in order, then accepts the next request.
- SEQ opcode 7 and opcode 12 -> rsp_err 1, result 0, carry 0. A following AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000, err 0.
- Assert rst_n low one cycle after issuing 2 ops -> no rsp_valid after release, idle 1, req_ready 1 on the first edge after release.
- Random opcodes 0..9 with random rsp_ready stalls, 1000 ops, checked against a reference model -> zero mismatches, no FIFO overflow assertion.
